// File: rtl/pool_window_gen_pkg.sv
// Shared definitions for the 2x2 pooling window producer and its consumers.
// Holds the pooling geometry, the element ordering inside a packed window,
// and a helper that pulls one element out of a packed window.
package pool_window_gen_pkg;

    localparam int POOL_K    = 2;
    localparam int WIN_ELEMS = POOL_K * POOL_K;

    // Element positions inside a packed window (element k at bits k*BW +: BW).
    localparam int WIN_TL = 0;
    localparam int WIN_TR = 1;
    localparam int WIN_BL = 2;
    localparam int WIN_BR = 3;

    // Widest pixel the extraction helper supports.
    localparam int MAX_BW = 32;

    // Extract element k of a packed window whose elements are bw bits wide.
    function automatic logic [MAX_BW-1:0] win_elem(
        input logic [WIN_ELEMS*MAX_BW-1:0] win,
        input int                          k,
        input int                          bw
    );
        logic [WIN_ELEMS*MAX_BW-1:0] shifted;
        logic [MAX_BW-1:0]           mask;
        shifted = win >> (k * bw);
        mask    = (MAX_BW'(1) << bw) - MAX_BW'(1);
        return shifted[MAX_BW-1:0] & mask;
    endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Stream bundle between the pixel producer, the window generator and the
// max unit.
//   in_valid/in_ready/in_data     : pixel stream into the generator
//   win_valid/win_ready/win_data  : packed 2x2 window stream out
//   win_last                      : final window of the frame
// slave  : the window generator's view
// master : the surrounding environment's view
interface pool_window_gen_if
    import pool_window_gen_pkg::*;
#(
    parameter int BITWIDTH = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [BITWIDTH-1:0]           in_data;
    logic                          win_valid;
    logic                          win_ready;
    logic [WIN_ELEMS*BITWIDTH-1:0] win_data;
    logic                          win_last;

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_last
    );

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_last
    );
endinterface

// File: rtl/pool_line_buffer.sv
// One-row pixel store for the window generator.
// Ports: clk, we (write enable), addr (column), wdata (pixel in),
//        rdata (combinational read of the same column).
// No reset: contents are don't-care until written, so this maps to LUT RAM.
module pool_line_buffer #(
    parameter int BITWIDTH = 8,
    parameter int DEPTH    = 28,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [BITWIDTH-1:0] wdata,
    output logic [BITWIDTH-1:0] rdata
);
    logic [BITWIDTH-1:0] mem [DEPTH];

    // Synchronous write of the even-row pixel at its column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window producer for the pooling max stage.
// Ports: clk, rst (async active-high), clear (sync frame abort),
//        bus (pixel in / packed window out, see pool_window_gen_if).
// Even rows are parked in a line buffer; on odd rows the even-column pixel
// and the line-buffer pixel above it are held, and the odd-column pixel
// completes the window, which loads the single output register.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    pool_window_gen_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int WW = WIN_ELEMS * BITWIDTH;

    localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT - 1);
    // Odd dimensions drop the trailing column/row, so the last full window
    // ends one position earlier.
    localparam logic [CW-1:0] LAST_COL = CW'((WIDTH  % 2 == 0) ? WIDTH  - 1 : WIDTH  - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'((HEIGHT % 2 == 0) ? HEIGHT - 1 : HEIGHT - 2);

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                win_valid_q, win_valid_d;
    logic                win_last_q, win_last_d;
    logic [WW-1:0]       win_data_q, win_data_d;
    logic [BITWIDTH-1:0] hold_top_q, hold_top_d;
    logic [BITWIDTH-1:0] hold_bot_q, hold_bot_d;

    logic                in_ready_s;
    logic                in_hs_s;
    logic                lb_we_s;
    logic [BITWIDTH-1:0] lb_rdata_s;

    pool_line_buffer #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (WIDTH),
        .AW       (CW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we_s),
        .addr  (col_q),
        .wdata (bus.in_data),
        .rdata (lb_rdata_s)
    );

    // Next-state logic: counters, hold registers, output register, buffer write.
    always_comb begin
        // Stall only when a window is waiting and not being drained this cycle.
        in_ready_s  = !(win_valid_q && !bus.win_ready);
        in_hs_s     = bus.in_valid && in_ready_s;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_data_d  = win_data_q;
        hold_top_d  = hold_top_q;
        hold_bot_d  = hold_bot_q;
        lb_we_s     = 1'b0;

        if (clear) begin
            // Abort wins over any handshake; an accepted pixel is discarded.
            col_d       = '0;
            row_d       = '0;
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end else begin
            if (win_valid_q && bus.win_ready) begin
                win_valid_d = 1'b0;
            end else begin
                win_valid_d = win_valid_q;
            end

            if (in_hs_s) begin
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    if (row_q == ROW_MAX) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                    row_d = row_q;
                end

                case ({row_q[0], col_q[0]})
                    2'b00, 2'b01: begin
                        lb_we_s = 1'b1;
                    end
                    2'b10: begin
                        hold_bot_d = bus.in_data;
                        hold_top_d = lb_rdata_s;
                    end
                    2'b11: begin
                        // A load overrides the drain above in the same cycle.
                        win_data_d[WIN_TL*BITWIDTH +: BITWIDTH] = hold_top_q;
                        win_data_d[WIN_TR*BITWIDTH +: BITWIDTH] = lb_rdata_s;
                        win_data_d[WIN_BL*BITWIDTH +: BITWIDTH] = hold_bot_q;
                        win_data_d[WIN_BR*BITWIDTH +: BITWIDTH] = bus.in_data;
                        win_valid_d = 1'b1;
                        win_last_d  = (row_q == LAST_ROW) && (col_q == LAST_COL);
                    end
                    default: begin
                        lb_we_s = 1'b0;
                    end
                endcase
            end else begin
                col_d = col_q;
                row_d = row_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
            hold_top_q  <= '0;
            hold_bot_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_data_q  <= win_data_d;
            hold_top_q  <= hold_top_d;
            hold_bot_q  <= hold_bot_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.win_last  = win_last_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x4 instance (dut_a) and a 5x3
// instance (dut_b). A frame model pushes expected windows (data, last flag,
// cycle of appearance) when a pixel is accepted; a monitor pops and compares
// them when a window is consumed, and checks the in_ready rule and that a
// stalled window holds its data.
module tb_pool_window_gen;
    import pool_window_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clear_a;
    logic clear_b;

    always #5 clk = ~clk;

    pool_window_gen_if #(.BITWIDTH(8)) ifa ();
    pool_window_gen_if #(.BITWIDTH(8)) ifb ();

    pool_window_gen #(.BITWIDTH(8), .WIDTH(4), .HEIGHT(4)) dut_a (
        .clk (clk), .rst (rst), .clear (clear_a), .bus (ifa.slave)
    );
    pool_window_gen #(.BITWIDTH(8), .WIDTH(5), .HEIGHT(3)) dut_b (
        .clk (clk), .rst (rst), .clear (clear_b), .bus (ifb.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [32:0] loga[$];   // {last, data} of consumed windows
    logic [32:0] logb[$];
    int          hs_log[$]; // acceptance cycles on dut_a

    logic [7:0]  pixm [2][64];
    int          pos_r [2];
    int          pos_c [2];
    logic        seen [2];
    int          appear [2];
    logic [31:0] first_d [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: record the pixel, emit the expected window on odd/odd.
    task automatic model_accept(input int which, input logic [7:0] d, input int now);
        int   w, h, r, c, lr, lc;
        exp_t e;
        w = (which == 0) ? 4 : 5;
        h = (which == 0) ? 4 : 3;
        r = pos_r[which];
        c = pos_c[which];
        lr = (h % 2 == 0) ? h - 1 : h - 2;
        lc = (w % 2 == 0) ? w - 1 : w - 2;
        pixm[which][r*w + c] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.data = {pixm[which][r*w + c], pixm[which][r*w + c - 1],
                      pixm[which][(r-1)*w + c], pixm[which][(r-1)*w + c - 1]};
            e.last = (r == lr) && (c == lc);
            e.cyc  = now + 1;
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (c == w - 1) begin
            pos_c[which] = 0;
            pos_r[which] = (r == h - 1) ? 0 : r + 1;
        end else begin
            pos_c[which] = c + 1;
        end
    endtask

    task automatic model_reset(input int which);
        pos_r[which] = 0;
        pos_c[which] = 0;
        seen[which]  = 1'b0;
        if (which == 0) qa.delete(); else qb.delete();
    endtask

    // Drive one pixel and wait (bounded) for its handshake.
    task automatic send(input int which, input logic [7:0] d);
        int   budget;
        logic rdy;
        budget = 0;
        @(negedge clk);
        if (which == 0) begin ifa.in_valid = 1'b1; ifa.in_data = d; end
        else            begin ifb.in_valid = 1'b1; ifb.in_data = d; end
        forever begin
            #4;
            rdy = (which == 0) ? ifa.in_ready : ifb.in_ready;
            if (rdy) begin
                model_accept(which, d, cyc);
                if (which == 0) hs_log.push_back(cyc);
                break;
            end
            budget++;
            checks++;
            assert (budget < 20) else begin
                failures++;
                $error("FAIL send_timeout observed=%0d expected=<20 cycles", budget);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int which);
        @(negedge clk);
        if (which == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    endtask

    // Monitor one instance just before the rising edge.
    task automatic mon(input int which);
        logic v, rd, ir, l;
        logic [31:0] d;
        exp_t e;
        int   qs;
        if (which == 0) begin
            v = ifa.win_valid; rd = ifa.win_ready; ir = ifa.in_ready; l = ifa.win_last; d = ifa.win_data;
            qs = qa.size();
        end else begin
            v = ifb.win_valid; rd = ifb.win_ready; ir = ifb.in_ready; l = ifb.win_last; d = ifb.win_data;
            qs = qb.size();
        end
        chk(which == 0 ? "in_ready_rule_a" : "in_ready_rule_b", 64'(ir), 64'(!(v && !rd)));
        if (v) begin
            if (!seen[which]) begin
                seen[which]    = 1'b1;
                appear[which]  = cyc;
                first_d[which] = d;
            end else begin
                chk("win_data_stable", 64'(d), 64'(first_d[which]));
            end
        end
        if (v && rd) begin
            checks++;
            assert (qs != 0) else begin
                failures++;
                $error("FAIL spurious_window observed=%0h expected=no window", d);
            end
            if (qs != 0) begin
                e = (which == 0) ? qa.pop_front() : qb.pop_front();
                chk("win_data", 64'(d), 64'(e.data));
                chk("win_last", 64'(l), 64'(e.last));
                chk("win_latency", 64'(appear[which]), 64'(e.cyc));
                if (which == 0) loga.push_back({l, d}); else logb.push_back({l, d});
            end
            seen[which] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        #4;
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.win_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.win_ready = 1'b1;
        model_reset(0);
        model_reset(1);
        #12;
        chk("reset_win_valid", 64'(ifa.win_valid), 64'd0);
        chk("reset_win_data",  64'(ifa.win_data),  64'd0);
        chk("reset_win_last",  64'(ifa.win_last),  64'd0);
        chk("reset_in_ready",  64'(ifa.in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic 4x4 frame.
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle(0);
        repeat (4) @(negedge clk);
        chk("basic_count", 64'(loga.size()), 64'd4);
        if (loga.size() == 4) begin
            chk("basic_w0", 64'(loga[0]), {31'd0, 1'b0, 32'h05040100});
            chk("basic_w1", 64'(loga[1]), {31'd0, 1'b0, 32'h07060302});
            chk("basic_w2", 64'(loga[2]), {31'd0, 1'b0, 32'h0D0C0908});
            chk("basic_w3", 64'(loga[3]), {31'd0, 1'b1, 32'h0F0E0B0A});
            chk("basic_elem_br", 64'(win_elem(128'(loga[2][31:0]), WIN_BR, 8)), 64'h0D);
        end
        chk("basic_drained", 64'(qa.size()), 64'd0);

        // Backpressure: stall the first window for three cycles.
        loga.delete();
        for (int i = 0; i < 6; i++) send(0, 8'(i));
        ifa.win_ready = 1'b0;
        fork
            send(0, 8'h06);
            begin
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", 64'(ifa.in_ready), 64'd0);
                chk("bp_hold_data",    64'(ifa.win_data), 64'h05040100);
                repeat (2) @(negedge clk);
                ifa.win_ready = 1'b1;
            end
        join
        for (int i = 7; i < 16; i++) send(0, 8'(i));
        idle(0);
        repeat (4) @(negedge clk);
        chk("bp_count", 64'(loga.size()), 64'd4);
        if (loga.size() == 4) begin
            chk("bp_w0", 64'(loga[0]), {31'd0, 1'b0, 32'h05040100});
            chk("bp_w3", 64'(loga[3]), {31'd0, 1'b1, 32'h0F0E0B0A});
        end

        // Odd size on the 5x3 instance.
        for (int i = 0; i < 15; i++) send(1, 8'(i));
        idle(1);
        repeat (4) @(negedge clk);
        chk("odd_count", 64'(logb.size()), 64'd2);
        if (logb.size() == 2) begin
            chk("odd_w0", 64'(logb[0]), {31'd0, 1'b0, 32'h06050100});
            chk("odd_w1", 64'(logb[1]), {31'd0, 1'b1, 32'h08070302});
        end
        chk("odd_drained", 64'(qb.size()), 64'd0);

        // Clear mid-frame, with a junk pixel offered during the clear cycle.
        for (int i = 0; i < 7; i++) send(0, 8'(i));
        @(negedge clk);
        clear_a = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = 8'hEE;
        @(negedge clk);
        clear_a = 1'b0; ifa.in_valid = 1'b0;
        model_reset(0);
        chk("clear_win_valid", 64'(ifa.win_valid), 64'd0);
        loga.delete();
        for (int i = 16; i < 32; i++) send(0, 8'(i));
        idle(0);
        repeat (4) @(negedge clk);
        chk("clear_count", 64'(loga.size()), 64'd4);
        if (loga.size() == 4) begin
            chk("clear_w0", 64'(loga[0]), {31'd0, 1'b0, 32'h15141110});
            chk("clear_w3", 64'(loga[3]), {31'd0, 1'b1, 32'h1F1E1B1A});
        end

        // Asynchronous reset while a window is pending.
        ifa.win_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 8'(i));
        idle(0);
        chk("pre_reset_valid", 64'(ifa.win_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 64'(ifa.win_valid), 64'd0);
        chk("async_reset_data",  64'(ifa.win_data),  64'd0);
        model_reset(0);
        @(negedge clk);
        rst = 1'b0;
        ifa.win_ready = 1'b1;
        loga.delete();
        for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle(0);
        repeat (4) @(negedge clk);
        chk("rst_count", 64'(loga.size()), 64'd4);
        if (loga.size() == 4) begin
            chk("rst_w0", 64'(loga[0]), {31'd0, 1'b0, 32'h05040100});
            chk("rst_w3", 64'(loga[3]), {31'd0, 1'b1, 32'h0F0E0B0A});
        end

        // Two frames back to back with in_valid held high.
        loga.delete();
        hs_log.delete();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send(0, 8'(i));
        idle(0);
        repeat (4) @(negedge clk);
        chk("b2b_count", 64'(loga.size()), 64'd8);
        chk("b2b_accepts", 64'(hs_log.size()), 64'd32);
        if (hs_log.size() == 32) begin
            c0 = hs_log[31] - hs_log[0];
            chk("b2b_no_gap", 64'(c0), 64'd31);
        end
        if (loga.size() == 8) begin
            chk("b2b_last4", 64'(loga[3][32]), 64'd1);
            chk("b2b_w4",    64'(loga[4]), {31'd0, 1'b0, 32'h05040100});
            chk("b2b_last8", 64'(loga[7][32]), 64'd1);
        end
        chk("b2b_drained", 64'(qa.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
